muldiv_ctrl: RTL

- Multi-cycle multiply/divide sequencer with HI/LO registers, sitting in EX beside the single-cycle ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Holds a busy counter modelling fixed latency and raises a stall request so the hazard unit freezes any HI/LO-dependent instruction until the result commits.

---
 rtl/muldiv_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : Multi-cycle multiply/divide sequencer with HI/LO registers.
//               Optional MADD/MSUB ops enabled by macro MULDIV_MADD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] c_op_mult  = 3'b000;
    localparam logic [2:0] c_op_multu = 3'b001;
    localparam logic [2:0] c_op_div   = 3'b010;
    localparam logic [2:0] c_op_divu  = 3'b011;
    localparam logic [2:0] c_op_mthi  = 3'b100;
    localparam logic [2:0] c_op_mtlo  = 3'b101;
`ifdef MULDIV_MADD_EN
    localparam logic [2:0] c_op_madd  = 3'b110;
    localparam logic [2:0] c_op_msub  = 3'b111;
`endif
    localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
    localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_wr;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;

    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic        w_dz;
    logic [31:0] w_sdiv;
    logic [31:0] w_udiv;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic        w_long;
    logic        w_wr;
    logic [3:0]  w_cnt;
    logic [63:0] w_res;

    assign w_sprod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_uprod = {32'd0, A} * {32'd0, B};
    assign w_dz    = (B == 32'd0);
    // Dividing by 1 in the MIN/-1 case yields the architected 0x80000000 rem 0
    // without ever evaluating an overflowing signed division.
    assign w_sdiv  = (w_dz || (A == 32'h8000_0000 && B == 32'hFFFF_FFFF)) ? 32'd1 : B;
    assign w_udiv  = w_dz ? 32'd1 : B;
    assign w_sq    = $signed(A) / $signed(w_sdiv);
    assign w_sr    = $signed(A) % $signed(w_sdiv);
    assign w_uq    = A / w_udiv;
    assign w_ur    = A % w_udiv;

    always_comb begin
        w_long = 1'b0;
        w_wr   = 1'b1;
        w_cnt  = c_mult_cnt;
        w_res  = 64'd0;
        case (op)
            c_op_mult:  begin w_long = 1'b1; w_res = w_sprod; end
            c_op_multu: begin w_long = 1'b1; w_res = w_uprod; end
            c_op_div:   begin w_long = 1'b1; w_cnt = c_div_cnt; w_wr = !w_dz; w_res = {w_sr, w_sq}; end
            c_op_divu:  begin w_long = 1'b1; w_cnt = c_div_cnt; w_wr = !w_dz; w_res = {w_ur, w_uq}; end
`ifdef MULDIV_MADD_EN
            c_op_madd:  begin w_long = 1'b1; w_res = {r_hi, r_lo} + w_sprod; end
            c_op_msub:  begin w_long = 1'b1; w_res = {r_hi, r_lo} - w_sprod; end
`endif
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr      <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_long) begin
                            r_pend_hi <= w_res[63:32];
                            r_pend_lo <= w_res[31:0];
                            r_wr      <= w_wr;
                            r_cnt     <= w_cnt;
                            r_busy    <= 1'b1;
                            r_state   <= S_RUN;
                        end else if (op == c_op_mthi) begin
                            r_hi <= A;
                        end else if (op == c_op_mtlo) begin
                            r_lo <= A;
                        end
                    end
                end
                S_RUN: begin
                    // Any start seen here is deliberately dropped.
                    if (r_cnt == 4'd1) begin
                        if (r_wr) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign stall = r_busy | (start & w_long);

endmodule
`default_nettype wire
